// File: rtl/softmax_ru_feeder_pkg.sv
// ----------------------------------------------------------------------------
// softmax_pkg
// Shared constants and types for the softmax RU feeder.
//   DATA_W / FRAC_W : signed Q6.10 logit format
//   IN0_W           : width of the RU in0 operand (sign-extended max)
//   N_MAX           : default buffer depth
//   feeder_state_t  : feeder FSM states
//   sext_in0()      : sign-extend a logit to the RU in0 width
// ----------------------------------------------------------------------------
package softmax_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam int IN0_W  = 32;
    localparam int N_MAX  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } feeder_state_t;

    function automatic logic [IN0_W-1:0] sext_in0(input logic [DATA_W-1:0] d);
        return {{(IN0_W-DATA_W){d[DATA_W-1]}}, d};
    endfunction

endpackage

// File: rtl/softmax_ru_feeder_if.sv
// ----------------------------------------------------------------------------
// softmax_ru_feeder_if
// Operand bus from the feeder to the RU stage.
//   ru_valid     : operand pair valid
//   ru_in0       : sign-extended vector max
//   ru_in1       : buffered logit
//   ru_last      : final element of the vector
//   ru_sel_mult  : RU multiplier select (high while issuing)
//   ru_sel_mux   : RU mux select (high while issuing)
//   ru_ready     : RU accepts the pair (only with SOFTMAX_FEEDER_BP_EN)
// Modports: master (feeder side), slave (RU side).
// ----------------------------------------------------------------------------
interface softmax_ru_feeder_if #(
    parameter int DATA_W = 16,
    parameter int IN0_W  = 32
);
    logic              ru_valid;
    logic [IN0_W-1:0]  ru_in0;
    logic [DATA_W-1:0] ru_in1;
    logic              ru_last;
    logic              ru_sel_mult;
    logic              ru_sel_mux;
`ifdef SOFTMAX_FEEDER_BP_EN
    logic              ru_ready;

    modport master (output ru_valid, ru_in0, ru_in1, ru_last, ru_sel_mult, ru_sel_mux,
                    input  ru_ready);
    modport slave  (input  ru_valid, ru_in0, ru_in1, ru_last, ru_sel_mult, ru_sel_mux,
                    output ru_ready);
`else
    modport master (output ru_valid, ru_in0, ru_in1, ru_last, ru_sel_mult, ru_sel_mux);
    modport slave  (input  ru_valid, ru_in0, ru_in1, ru_last, ru_sel_mult, ru_sel_mux);
`endif
endinterface

// File: rtl/softmax_ru_feeder_buf.sv
// ----------------------------------------------------------------------------
// softmax_feeder_buf
// Logit buffer: DEPTH x WIDTH, one write port, one read port, 1-cycle
// registered read (maps onto block RAM with its output register).
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_wr_en/addr/data : write port
//   i_rd_en/addr      : read request; data appears on o_rd_data next cycle
//   o_rd_data         : registered read data, held while i_rd_en is low
// ----------------------------------------------------------------------------
module softmax_feeder_buf #(
    parameter  int DEPTH  = 64,
    parameter  int WIDTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/softmax_ru_feeder.sv
// ----------------------------------------------------------------------------
// softmax_ru_feeder
// Loads one vector of Q6.10 logits while tracking its maximum, then streams
// one RU operand pair per element (in0 = max, in1 = logit, load order).
// Optional feature macro: SOFTMAX_FEEDER_BP_EN adds RU back-pressure
// (ru.ru_ready); without it the RU accepts one pair every cycle.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : global enable, low freezes all state and outputs
//   i_start, i_len : begin a vector of i_len (1..N_MAX) elements
//   i_valid,i_data : logit input; transfer = i_valid & o_ready & i_en
//   o_ready        : accepting logits (LOAD)
//   o_busy         : LOAD or ISSUE
//   o_done         : one-cycle pulse after the last pair leaves
//   ru             : RU operand bus (master modport)
// ----------------------------------------------------------------------------
module softmax_ru_feeder #(
    parameter  int N_MAX  = 64,
    parameter  int DATA_W = 16,
    parameter  int IN0_W  = 32,
    localparam int LEN_W  = $clog2(N_MAX) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    input  logic                     i_valid,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_ready,
    output logic                     o_busy,
    output logic                     o_done,
    softmax_ru_feeder_if.master      ru
);
    import softmax_pkg::*;

    localparam int ADDR_W = $clog2(N_MAX);

    feeder_state_t     r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_wr_idx;
    logic [LEN_W-1:0]  r_rd_idx;
    logic [DATA_W-1:0] r_max;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_ru_valid;
    logic [IN0_W-1:0]  r_ru_in0;
    logic              r_ru_last;
    logic              r_ru_sel;

    logic              w_ru_ready;
    logic              w_xfer;
    logic              w_start_ok;
    logic              w_last_wr;
    logic              w_adv;
    logic              w_more;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_data;

`ifdef SOFTMAX_FEEDER_BP_EN
    assign w_ru_ready = ru.ru_ready;
`else
    assign w_ru_ready = 1'b1;
`endif

    // r_ready is only ever high in LOAD, so it also gates stray i_valid.
    assign w_xfer     = i_en & i_valid & r_ready;
    assign w_start_ok = i_start && (i_len != '0) && (i_len <= LEN_W'(N_MAX));
    assign w_last_wr  = (r_wr_idx == r_len - 1'b1);
    // Output slot can take a new pair when empty or being consumed this cycle.
    assign w_adv      = ~r_ru_valid | w_ru_ready;
    assign w_more     = (r_rd_idx < r_len);
    // The read is launched on the same edge that raises ru_valid, so the
    // RAM output register lines up with valid/in0/last without extra stages.
    assign w_rd_en    = i_en & (r_state == ISSUE) & w_adv & w_more;

    softmax_feeder_buf #(
        .DEPTH (N_MAX),
        .WIDTH (DATA_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_xfer),
        .i_wr_addr (r_wr_idx[ADDR_W-1:0]),
        .i_wr_data (i_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_idx[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_max      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ru_valid <= 1'b0;
            r_ru_in0   <= '0;
            r_ru_last  <= 1'b0;
            r_ru_sel   <= 1'b0;
        end else if (i_en) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_len    <= i_len;
                        r_wr_idx <= '0;
                        r_rd_idx <= '0;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        // Strict compare: on a tie the earlier element stays.
                        if (r_wr_idx == '0 || $signed(i_data) > $signed(r_max)) begin
                            r_max <= i_data;
                        end
                        if (w_last_wr) begin
                            r_ready  <= 1'b0;
                            r_ru_sel <= 1'b1;
                            r_state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (w_adv) begin
                        if (w_more) begin
                            r_ru_valid <= 1'b1;
                            r_ru_in0   <= sext_in0(r_max);
                            r_ru_last  <= (r_rd_idx == r_len - 1'b1);
                            r_rd_idx   <= r_rd_idx + 1'b1;
                        end else begin
                            // Last pair has just been taken.
                            r_ru_valid <= 1'b0;
                            r_ru_last  <= 1'b0;
                            r_ru_sel   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready        = r_ready;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign ru.ru_valid    = r_ru_valid;
    assign ru.ru_in0      = r_ru_in0;
    assign ru.ru_in1      = w_rd_data;
    assign ru.ru_last     = r_ru_last;
    assign ru.ru_sel_mult = r_ru_sel;
    assign ru.ru_sel_mux  = r_ru_sel;
endmodule
